// File: rtl/sobel_kernel_core.sv
// sobel_kernel_core: 3x3 Sobel gradient magnitude over a column-streamed window,
// three-stage pipeline (window, Gx/Gy, saturated |Gx|+|Gy|) that stalls on Enable.
module sobel_kernel_core #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       Enable,
    input  logic [7:0] Row0In,
    input  logic [7:0] Row1In,
    input  logic [7:0] Row2In,
    output logic [7:0] EdgeOut,
    output logic       ValidOut,
    output logic       FrameDone
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [2:0][2:0][7:0]   win_q, win_d;
    logic                   wv_q, wv_d;
    logic [10:0]            gx_q, gx_d, gy_q, gy_d;
    logic                   gv_q, gv_d;
    logic [7:0]             edge_q, edge_d;
    logic                   valid_q, valid_d;
    logic                   fd_q, fd_d;
    logic                   last_col, last_row;
    logic [10:0]            ax, ay;
    logic [11:0]            mag;

    always_comb begin
        last_col = col_q == CW'(IMG_WIDTH - 1);
        last_row = row_q == RW'(IMG_HEIGHT - 1);
        col_d    = Enable ? (last_col ? '0 : col_q + CW'(1)) : col_q;
        row_d    = (Enable && last_col) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
        win_d[0] = Enable ? {Row0In, win_q[0][2:1]} : win_q[0];
        win_d[1] = Enable ? {Row1In, win_q[1][2:1]} : win_q[1];
        win_d[2] = Enable ? {Row2In, win_q[2][2:1]} : win_q[2];
        wv_d     = Enable ? (col_q >= CW'(2) && row_q >= RW'(2)) : wv_q;
        // two's-complement differences; 11 bits cover -1020..+1020
        gx_d     = Enable ? ({3'b0, win_q[0][2]} + {2'b0, win_q[1][2], 1'b0} + {3'b0, win_q[2][2]}
                           - {3'b0, win_q[0][0]} - {2'b0, win_q[1][0], 1'b0} - {3'b0, win_q[2][0]})
                          : gx_q;
        gy_d     = Enable ? ({3'b0, win_q[2][0]} + {2'b0, win_q[2][1], 1'b0} + {3'b0, win_q[2][2]}
                           - {3'b0, win_q[0][0]} - {2'b0, win_q[0][1], 1'b0} - {3'b0, win_q[0][2]})
                          : gy_q;
        gv_d     = Enable ? wv_q : gv_q;
        ax       = gx_q[10] ? -gx_q : gx_q;
        ay       = gy_q[10] ? -gy_q : gy_q;
        mag      = {1'b0, ax} + {1'b0, ay};
        edge_d   = (Enable && gv_q) ? (mag > 12'd255 ? 8'hff : mag[7:0]) : edge_q;
        valid_d  = Enable && gv_q;
        fd_d     = Enable && last_col && last_row;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            wv_q    <= 1'b0;
            gx_q    <= '0;
            gy_q    <= '0;
            gv_q    <= 1'b0;
            edge_q  <= '0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            wv_q    <= wv_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            gv_q    <= gv_d;
            edge_q  <= edge_d;
            valid_q <= valid_d;
            fd_q    <= fd_d;
        end
    end

    assign EdgeOut   = edge_q;
    assign ValidOut  = valid_q;
    assign FrameDone = fd_q;
endmodule

// File: tb/tb_sobel_kernel_core.sv
// tb_sobel_kernel_core: directed frames on an 8x4 image; driver pushes expected
// results with their due Enable-edge index, a monitor pops on ValidOut.
module tb_sobel_kernel_core;
    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Enable = 1'b1;
    logic [7:0] Row0In = 8'haa, Row1In = 8'h55, Row2In = 8'h33;
    logic [7:0] EdgeOut;
    logic       ValidOut, FrameDone;

    typedef struct {logic [7:0] v; int due;} exp_t;
    exp_t q[$];
    exp_t mon_e;
    int   total = 0, bad = 0, n_en = 0, n_valid = 0, n_fd = 0, base = 0;
    logic fd_exp = 1'b0;

    sobel_kernel_core #(.IMG_WIDTH(8), .IMG_HEIGHT(4)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Enable(Enable),
        .Row0In(Row0In), .Row1In(Row1In), .Row2In(Row2In),
        .EdgeOut(EdgeOut), .ValidOut(ValidOut), .FrameDone(FrameDone)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endtask

    // test images: uniform, step, h-ramp, v-ramp, falling ramp, diagonal
    function automatic logic [7:0] img(int t, int r, int c);
        case (t)
            0: return 8'd100;
            1: return c < 4 ? 8'd0 : 8'd255;
            2: return 8'(10 * c);
            3: return 8'(30 * r);
            4: return 8'(200 - 20 * c);
            default: return 8'(10 * c + 30 * r);
        endcase
    endfunction

    function automatic logic [7:0] expv(int t, int c);
        case (t)
            0: return 8'd0;
            1: return (c == 4 || c == 5) ? 8'd255 : 8'd0;
            2: return 8'd80;
            3: return 8'd240;
            4: return 8'd160;
            default: return 8'd255;
        endcase
    endfunction

    task automatic sample(int t, int r, int c);
        @(negedge CLK);
        Enable = 1'b1;
        Row2In = img(t, r, c);
        Row1In = r >= 1 ? img(t, r - 1, c) : 8'd0;
        Row0In = r >= 2 ? img(t, r - 2, c) : 8'd0;
        n_en++;
        fd_exp = (r == 3 && c == 7);
        if (r >= 2 && c >= 2) q.push_back('{expv(t, c), n_en + 2});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(logic [7:0] hold);
        @(negedge CLK);
        Enable = 1'b0;
        Row0In = 8'hde;
        Row1In = 8'had;
        Row2In = 8'hbe;
        fd_exp = 1'b0;
        @(posedge CLK);
        #1;
        chk("stall_valid", ValidOut, 0);
        chk("stall_hold", EdgeOut, hold);
    endtask

    task automatic frame(int t);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                sample(t, r, c);
                if (r == 2 && (c == 5 || c == 6)) repeat (2) idle(expv(t, c - 2));
            end
    endtask

    always @(posedge CLK) begin
        #1;
        chk("framedone", FrameDone, fd_exp);
        if (FrameDone) n_fd++;
        if (ValidOut) begin
            n_valid++;
            if (q.size() == 0) chk("spurious_valid", ValidOut, 0);
            else begin
                mon_e = q.pop_front();
                chk("edge_val", EdgeOut, mon_e.v);
                chk("edge_due", n_en, mon_e.due);
            end
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_edge", EdgeOut, 0);
        chk("rst_valid", ValidOut, 0);
        chk("rst_fd", FrameDone, 0);
        @(negedge CLK);
        Reset_n = 1'b1;
        Enable = 1'b0;
        for (int t = 0; t < 6; t++) frame(t);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) sample(1, r, c);
        for (int c = 0; c < 5; c++) sample(1, 2, c);
        @(negedge CLK);
        Reset_n = 1'b0;
        Enable = 1'b1;
        fd_exp = 1'b0;
        q.delete();
        @(posedge CLK);
        #1;
        chk("midrst_edge", EdgeOut, 0);
        chk("midrst_valid", ValidOut, 0);
        chk("midrst_fd", FrameDone, 0);
        @(negedge CLK);
        Reset_n = 1'b1;
        Enable = 1'b0;
        base = n_valid;
        frame(2);
        sample(0, 0, 0);
        sample(0, 0, 1);
        idle(8'd80);
        chk("reset_frame_valids", n_valid - base, 12);
        chk("queue_empty", q.size(), 0);
        chk("total_valid", n_valid, 85);
        chk("framedone_count", n_fd, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sobel_kernel_core.md
SOBEL_KERNEL_CORE -- requirements
Module: sobel_kernel_core

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, pixels per line (min 3).
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, lines per frame (min 3).
REQ-003 The block SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port Reset_n  input  1  synchronous active-low reset.
REQ-005 The block SHALL have port Enable  input  1  accept one pixel column and advance the pipeline this cycle.
REQ-006 The block SHALL have port Row0In  input  8  top-line pixel (oldest line-buffer output).
REQ-007 The block SHALL have port Row1In  input  8  middle-line pixel (first line-buffer output).
REQ-008 The block SHALL have port Row2In  input  8  current-line pixel (live stream).
REQ-009 The block SHALL have port EdgeOut  output  8  saturated gradient magnitude.
REQ-010 The block SHALL have port ValidOut  output  1  EdgeOut carries a new valid result this cycle.
REQ-011 The block SHALL have port FrameDone  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 With Enable=1, each edge SHALL shift the 3x3 window left: column 0 <= column 1, column 1 <= column 2, column 2 <= {Row0In, Row1In, Row2In}.
REQ-013 With Enable=0, window, counters, and pipeline registers SHALL hold, EdgeOut SHALL hold, ValidOut SHALL be 0, and FrameDone SHALL be 0.
REQ-014 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL give the Row2In position of the accepted sample, increment on Enable, wrap col at IMG_WIDTH-1 incrementing row, and wrap row at IMG_HEIGHT-1 to 0.
REQ-015 An accepted sample SHALL mark its window valid iff col>=2 and row>=2, so windows straddling line boundaries or the first two lines are suppressed; there SHALL be (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid outputs per frame.
REQ-016 Window pixel p[r][c] (r=0 top, c=0 oldest column) SHALL give Gx = (p02+2p12+p22) - (p00+2p10+p20) and Gy = (p20+2p21+p22) - (p00+2p01+p02), as 11-bit signed values in range -1020..+1020.
REQ-017 Magnitude SHALL be |Gx|+|Gy| (12-bit unsigned, max 2040), and EdgeOut SHALL be min(magnitude, 255).
REQ-018 The pipeline SHALL be three stages: window register at edge k, Gx/Gy register at edge k+1, and EdgeOut/ValidOut register at edge k+2, counting Enable=1 edges only.
REQ-019 The valid flag SHALL travel through the pipeline with its data and stall with it, so a window accepted before a stall emits ValidOut=1 only on the 2nd subsequent Enable=1 edge.
REQ-020 FrameDone SHALL be registered and assert for exactly one cycle, on the edge accepting col=IMG_WIDTH-1 and row=IMG_HEIGHT-1.
REQ-021 Results of the last valid windows of a frame SHALL drain as the next frame's first samples are accepted, with no extra flush cycles.
REQ-022 No combinational path SHALL exist from inputs to outputs.

Reset
REQ-023 With Reset_n=0 at a rising edge, col, row, window, pipeline registers, EdgeOut, ValidOut, and FrameDone SHALL all become 0, regardless of Enable.
REQ-024 Reset SHALL take priority over Enable.
REQ-025 Reset mid-frame SHALL discard in-flight results, with no ValidOut for pre-reset data, and the next accepted sample SHALL be treated as col=0, row=0.

Verification (IMG_WIDTH=8, IMG_HEIGHT=4, Enable=1 unless stated)
REQ-026 A uniform frame of all pixels 100 SHALL produce 12 ValidOut pulses with EdgeOut=0 each, and FrameDone after the 32nd sample.
REQ-027 Columns 0..3=0 and 4..7=255 on all rows SHALL produce EdgeOut=255 (Gx=1020 saturated) for windows spanning the step, and 0 elsewhere.
REQ-028 A horizontal ramp with pixel = 10*col on all rows SHALL produce EdgeOut=80 on every valid output.
REQ-029 Toggling Enable 1-0-0-1 around a valid window SHALL hold EdgeOut and keep ValidOut=0 while Enable=0, with the result appearing on the 2nd Enable=1 edge after acceptance, unchanged in value.
REQ-030 Asserting Reset_n=0 for 1 cycle at col=5, row=2, then streaming a full frame, SHALL give all outputs 0 after reset, no stale ValidOut, and exactly 12 valid outputs in the new frame.
REQ-031 Two back-to-back frames SHALL produce two FrameDone pulses 32 Enable cycles apart and 24 total ValidOut pulses, with the first frame's last result emitted during the second frame's first 2 samples.
